// File: rtl/ps2_key_state_decoder_if.sv
// Byte-in / key-event-out bundle between PS2_Controller, the scancode decoder and
// MasterFSM. The master side drives the received byte; the slave side reports key state.
interface ps2_key_state_decoder_if #(
    parameter int NUM_KEYS = 29
);
    logic [7:0]          recievedData;
    logic                recievedNewData;
    logic                clearKeys;
    logic [NUM_KEYS-1:0] keyState;
    logic                keyPressPulse;
    logic                keyReleasePulse;
    logic [4:0]          keyIndex;
    logic                anyKeyHeld;
    logic                prefixTimeout;

    modport master (
        output recievedData, recievedNewData, clearKeys,
        input  keyState, keyPressPulse, keyReleasePulse, keyIndex, anyKeyHeld, prefixTimeout
    );

    modport slave (
        input  recievedData, recievedNewData, clearKeys,
        output keyState, keyPressPulse, keyReleasePulse, keyIndex, anyKeyHeld, prefixTimeout
    );
endinterface

// File: rtl/ps2_key_state_decoder.sv
// PS/2 Set-2 scancode decoder: tracks F0/E0 prefixes, the held-key vector and press/release
// pulses on CLOCK_50. Define PS2_TYPEMATIC_PRESS_EN to re-pulse on typematic repeats.
module ps2_key_state_decoder #(
    parameter int NUM_KEYS       = 29,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TIMEOUT_W      = 22
) (
    input logic CLOCK_50,
    input logic resetn,
    ps2_key_state_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t                state, stateNext;
    logic [TIMEOUT_W-1:0]  toCount, toCountNext;
    logic [NUM_KEYS-1:0]   keys_p0, keysNext;
    logic                  press_p0, pressNext;
    logic                  release_p0, releaseNext;
    logic                  timeout_p0, timeoutNext;
    logic [4:0]            idx_p0, idxNext;
    logic                  anyHeld_p1;
    logic [5:0]            hit;
    logic                  codeMapped;
    logic [4:0]            codeIdx;

    // Returns {mapped, index} for a make code.
    function automatic logic [5:0] mapCode(input logic [7:0] code);
        case (code)
            8'h0E: return {1'b1, 5'd0};
            8'h16: return {1'b1, 5'd1};
            8'h1E: return {1'b1, 5'd2};
            8'h26: return {1'b1, 5'd3};
            8'h25: return {1'b1, 5'd4};
            8'h2E: return {1'b1, 5'd5};
            8'h36: return {1'b1, 5'd6};
            8'h3D: return {1'b1, 5'd7};
            8'h3E: return {1'b1, 5'd8};
            8'h46: return {1'b1, 5'd9};
            8'h45: return {1'b1, 5'd10};
            8'h4E: return {1'b1, 5'd11};
            8'h55: return {1'b1, 5'd12};
            8'h66: return {1'b1, 5'd13};
            8'h0D: return {1'b1, 5'd14};
            8'h15: return {1'b1, 5'd15};
            8'h1D: return {1'b1, 5'd16};
            8'h24: return {1'b1, 5'd17};
            8'h2D: return {1'b1, 5'd18};
            8'h2C: return {1'b1, 5'd19};
            8'h35: return {1'b1, 5'd20};
            8'h3C: return {1'b1, 5'd21};
            8'h43: return {1'b1, 5'd22};
            8'h44: return {1'b1, 5'd23};
            8'h4D: return {1'b1, 5'd24};
            8'h54: return {1'b1, 5'd25};
            8'h5B: return {1'b1, 5'd26};
            8'h5D: return {1'b1, 5'd27};
            8'h29: return {1'b1, 5'd28};
            default: return 6'd0;
        endcase
    endfunction

    assign hit        = mapCode(bus.recievedData);
    assign codeMapped = hit[5];
    assign codeIdx    = hit[4:0];

    always_comb begin
        stateNext   = state;
        toCountNext = toCount;
        keysNext    = keys_p0;
        pressNext   = 1'b0;
        releaseNext = 1'b0;
        timeoutNext = 1'b0;
        idxNext     = idx_p0;

        // clearKeys outranks a coincident strobe; keyIndex deliberately keeps its value
        if (bus.clearKeys) begin
            keysNext    = '0;
            stateNext   = IDLE;
            toCountNext = '0;
        end else if (bus.recievedNewData) begin
            toCountNext = '0;
            case (state)
                IDLE: begin
                    if (bus.recievedData == 8'hF0) begin
                        stateNext = BREAK;
                    end else if (bus.recievedData == 8'hE0) begin
                        stateNext = EXT;
                    end else if (codeMapped) begin
                        keysNext[codeIdx] = 1'b1;
`ifdef PS2_TYPEMATIC_PRESS_EN
                        pressNext = 1'b1;
                        idxNext   = codeIdx;
`else
                        if (!keys_p0[codeIdx]) begin
                            pressNext = 1'b1;
                            idxNext   = codeIdx;
                        end
`endif
                    end
                end
                BREAK: begin
                    stateNext = IDLE;
                    if (codeMapped) begin
                        keysNext[codeIdx] = 1'b0;
                        if (keys_p0[codeIdx]) begin
                            releaseNext = 1'b1;
                            idxNext     = codeIdx;
                        end
                    end
                end
                EXT:       stateNext = (bus.recievedData == 8'hF0) ? EXT_BREAK : IDLE;
                EXT_BREAK: stateNext = IDLE;
                default:   stateNext = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (toCount == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                stateNext   = IDLE;
                timeoutNext = 1'b1;
                toCountNext = '0;
            end else begin
                toCountNext = toCount + TIMEOUT_W'(1);
            end
        end else begin
            toCountNext = '0;
        end
    end

    // Stage p0: decoded key state, pulses and FSM register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            toCount    <= '0;
            keys_p0    <= '0;
            press_p0   <= 1'b0;
            release_p0 <= 1'b0;
            timeout_p0 <= 1'b0;
            idx_p0     <= 5'd0;
        end else begin
            state      <= stateNext;
            toCount    <= toCountNext;
            keys_p0    <= keysNext;
            press_p0   <= pressNext;
            release_p0 <= releaseNext;
            timeout_p0 <= timeoutNext;
            idx_p0     <= idxNext;
        end
    end

    // Stage p1: held-key summary trails keyState by one cycle
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            anyHeld_p1 <= 1'b0;
        end else begin
            anyHeld_p1 <= |keys_p0;
        end
    end

    assign bus.keyState        = keys_p0;
    assign bus.keyPressPulse   = press_p0;
    assign bus.keyReleasePulse = release_p0;
    assign bus.keyIndex        = idx_p0;
    assign bus.anyKeyHeld      = anyHeld_p1;
    assign bus.prefixTimeout   = timeout_p0;

endmodule

// File: doc/ps2_key_state_decoder.md
Name: ps2_key_state_decoder

Overview:
Synchronous PS/2 Set-2 scancode decoder between the PS2_Controller byte interface and MasterFSM / mainStateHandler. It consumes the received byte and its one-cycle strobe. It tracks break (F0) and extended (E0) prefixes and maintains the held-key vector. It emits single-cycle press/release pulses with the key index, replacing the clock-less posedge-strobe decode. All logic is on CLOCK_50.

Parameters:
NUM_KEYS, 29, width of keyState; the mapping below is fixed at 29 entries.
TIMEOUT_CYCLES, 2500000, CLOCK_50 cycles a prefix state may wait for its next byte before abandoning the sequence (50 ms).
TIMEOUT_W, 22, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
recievedData  in  8  byte from PS2_Controller; valid only while recievedNewData=1
recievedNewData  in  1  one-cycle strobe, synchronous to CLOCK_50
clearKeys  in  1  synchronous clear of all key state and the FSM
keyState  out  NUM_KEYS  1 = key currently held, indexed per the mapping below
keyPressPulse  out  1  one cycle; a key transitioned released->held
keyReleasePulse  out  1  one cycle; a key transitioned held->released
keyIndex  out  5  index of the last key reported; updates with either pulse and holds otherwise
anyKeyHeld  out  1  OR-reduction of keyState, registered
prefixTimeout  out  1  one cycle; a pending prefix was abandoned

Behaviour:
- Reset (resetn=0, async): keyState=0, all pulses 0, keyIndex=0, anyKeyHeld=0, FSM=IDLE, timeout counter=0.
- Key mapping (index:code):
  - 0:0E, 1:16, 2:1E, 3:26, 4:25, 5:2E, 6:36, 7:3D, 8:3E, 9:46, 10:45
  - 11:4E, 12:55, 13:66, 14:0D, 15:15, 16:1D, 17:24, 18:2D, 19:2C, 20:35
  - 21:3C, 22:43, 23:44, 24:4D, 25:54, 26:5B, 27:5D, 28:29
  - Any other code is unmapped.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK. Transitions occur only on a cycle with recievedNewData=1, except timeout.
- IDLE:
  - F0 -> BREAK.
  - E0 -> EXT.
  - Mapped code -> set keyState[i]. If the bit was previously 0, pulse keyPressPulse and set keyIndex=i.
  - Unmapped code, FA, AA, EE, FE -> no effect.
- BREAK:
  - Mapped code -> clear keyState[i]. If the bit was previously 1, pulse keyReleasePulse and set keyIndex=i.
  - Any byte returns to IDLE, including unmapped codes and F0/E0.
- EXT: F0 -> EXT_BREAK; any other byte -> IDLE with no key effect (extended keys are ignored).
- EXT_BREAK: any byte -> IDLE, no effect.
- Latency: keyState, pulses, keyIndex and FSM update on the edge after the strobe cycle (1-cycle latency). anyKeyHeld follows keyState one cycle later.
- Timeout:
  - The counter clears on every strobe and in IDLE, and increments each cycle in the other states.
  - When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, prefixTimeout pulses, keyState unchanged.
  - If a strobe arrives in the same cycle as the timeout, the strobe wins: the byte is processed normally and no prefixTimeout pulse is issued.
- clearKeys=1: keyState=0, FSM=IDLE, counter=0, no pulses.
  - Overrides a coincident strobe; that byte is dropped.
  - keyIndex holds its value.
- Pulses are never both high in the same cycle. Neither pulse repeats without an intervening state change, except as described under Optional Feature.
- Reset mid-sequence (e.g. after F0): the following make byte is treated as a press.

Optional Feature:
PS2_TYPEMATIC_PRESS_EN
- Defined: a make code for a key already held (typematic repeat) re-issues keyPressPulse with keyIndex=i. keyState is unchanged.
- Undefined (default): repeats of a held key produce no pulse.
- Release behaviour is identical in both builds.

Test Plan:
- Reset, then strobe 15 -> next cycle: keyState[15]=1, keyPressPulse=1 for exactly 1 cycle, keyIndex=15; anyKeyHeld=1 one cycle after that.
- 15, F0, 15 on separate strobes -> F0 produces no pulse; final 15 gives keyReleasePulse=1, keyIndex=15, keyState=0.
- 15, then 15 again ×3 -> default build: one press pulse in total. With PS2_TYPEMATIC_PRESS_EN: four press pulses. keyState[15]=1 throughout.
- E0, 75 then E0, F0, 75 -> no pulses, keyState unchanged, FSM ends in IDLE; 1D, 29 held -> keyState bits 16 and 28 set.
- F0 then no strobe for TIMEOUT_CYCLES (set to 16 in the bench) -> prefixTimeout pulses on cycle 16, FSM=IDLE; a following 29 is a press, not a release.
- Hold 0E and 66, assert clearKeys in the same cycle as a strobe of 29 -> keyState=0, no pulses, 29 dropped; async resetn low mid-BREAK -> all outputs 0 immediately.
